// File: rtl/msx_audio_mixer.sv
// msx_audio_mixer
//   Mixes the MSX sound sources (OPLL, OPL3, two SCC, PSG, turbo-R PCM and
//   tape monitor) into one signed 16-bit stereo pair at a fixed sample rate.
//   Pipeline: capture -> scale -> sum -> DC block + volume + saturate.
//   The output register is updated, and sample_stb_o pulses, 4 cycles after
//   each capture.
//
// Ports
//   clk_sys        system clock
//   reset          synchronous, active-high reset
//   opll_i         signed OPLL sample (mono, feeds both channels)
//   opl3_l_i/_r_i  signed OPL3 left / right
//   scc1_*/scc2_*  signed 15-bit SCC left / right for slot 1 and slot 2
//   psg_i          unsigned 9-bit PSG level, midscale 256
//   pcm_i          signed 8-bit turbo-R PCM
//   tape_i         cassette input bit
//   tape_en        enables the tape monitor
//   vol_i          master volume, 7 = full, 0 = mute
//   audio_l_o/_r_o signed mixed output
//   sample_stb_o   one-cycle pulse when the outputs update
module msx_audio_mixer #(
  parameter int CE_DIV   = 448,
  parameter int SUM_W    = 20,
  parameter int DC_BLOCK = 1,
  parameter int DC_SHIFT = 10
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic signed [15:0] opll_i,
  input  logic signed [15:0] opl3_l_i,
  input  logic signed [15:0] opl3_r_i,
  input  logic signed [14:0] scc1_l_i,
  input  logic signed [14:0] scc1_r_i,
  input  logic signed [14:0] scc2_l_i,
  input  logic signed [14:0] scc2_r_i,
  input  logic        [8:0]  psg_i,
  input  logic signed [7:0]  pcm_i,
  input  logic               tape_i,
  input  logic               tape_en,
  input  logic        [2:0]  vol_i,
  output logic signed [15:0] audio_l_o,
  output logic signed [15:0] audio_r_o,
  output logic               sample_stb_o
);

  localparam int CNT_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam int Y_W   = SUM_W + 1;              // x - dc needs one extra bit
  localparam int ACC_W = SUM_W + DC_SHIFT + 1;   // dc with DC_SHIFT fraction bits

  localparam logic signed [SUM_W-1:0] PSG_MID = SUM_W'(16384);
  localparam logic signed [SUM_W-1:0] TAPE_HI = SUM_W'(4096);
  localparam logic signed [SUM_W-1:0] TAPE_LO = -SUM_W'(4096);
  localparam logic signed [Y_W-1:0]   OUT_MAX = Y_W'(32767);
  localparam logic signed [Y_W-1:0]   OUT_MIN = -Y_W'(32768);

  // Sample divider
  logic [CNT_W-1:0] div_cnt;
  logic             capture;

  assign capture = (div_cnt == CNT_W'(CE_DIV - 1));

  // Divider counts 0..CE_DIV-1 and wraps
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (capture) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  // Stage 0: input capture
  logic               valid0;
  logic signed [15:0] s0_opll, s0_opl3_l, s0_opl3_r;
  logic signed [14:0] s0_scc1_l, s0_scc1_r, s0_scc2_l, s0_scc2_r;
  logic        [8:0]  s0_psg;
  logic signed [7:0]  s0_pcm;
  logic               s0_tape, s0_tape_en;
  logic        [2:0]  s0_vol;

  // Inputs are only looked at on the capture cycle
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      valid0     <= 1'b0;
      s0_opll    <= '0;
      s0_opl3_l  <= '0;
      s0_opl3_r  <= '0;
      s0_scc1_l  <= '0;
      s0_scc1_r  <= '0;
      s0_scc2_l  <= '0;
      s0_scc2_r  <= '0;
      s0_psg     <= '0;
      s0_pcm     <= '0;
      s0_tape    <= 1'b0;
      s0_tape_en <= 1'b0;
      s0_vol     <= '0;
    end else begin
      valid0 <= capture;
      if (capture) begin
        s0_opll    <= opll_i;
        s0_opl3_l  <= opl3_l_i;
        s0_opl3_r  <= opl3_r_i;
        s0_scc1_l  <= scc1_l_i;
        s0_scc1_r  <= scc1_r_i;
        s0_scc2_l  <= scc2_l_i;
        s0_scc2_r  <= scc2_r_i;
        s0_psg     <= psg_i;
        s0_pcm     <= pcm_i;
        s0_tape    <= tape_i;
        s0_tape_en <= tape_en;
        s0_vol     <= vol_i;
      end
    end
  end

  // Stage 1: scale every source to SUM_W signed
  logic signed [SUM_W-1:0] sc_scc1_l, sc_scc1_r, sc_scc2_l, sc_scc2_r;
  logic signed [SUM_W-1:0] sc_psg, sc_pcm, sc_tape;

  // Combinational scaling of the captured sources
  always_comb begin
    // SCC is 15 bits: sign-extend then double to match the 16-bit sources
    sc_scc1_l = {{(SUM_W-16){s0_scc1_l[14]}}, s0_scc1_l, 1'b0};
    sc_scc1_r = {{(SUM_W-16){s0_scc1_r[14]}}, s0_scc1_r, 1'b0};
    sc_scc2_l = {{(SUM_W-16){s0_scc2_l[14]}}, s0_scc2_l, 1'b0};
    sc_scc2_r = {{(SUM_W-16){s0_scc2_r[14]}}, s0_scc2_r, 1'b0};
    // PSG is unsigned; re-centre so level 256 contributes nothing
    sc_psg    = $signed({{(SUM_W-16){1'b0}}, 1'b0, s0_psg, 6'b000000}) - PSG_MID;
    sc_pcm    = {{(SUM_W-16){s0_pcm[7]}}, s0_pcm, 8'h00};
    if (!s0_tape_en) begin
      sc_tape = '0;
    end else if (s0_tape) begin
      sc_tape = TAPE_HI;
    end else begin
      sc_tape = TAPE_LO;
    end
  end

  logic                    valid1;
  logic signed [SUM_W-1:0] s1_opll, s1_opl3_l, s1_opl3_r;
  logic signed [SUM_W-1:0] s1_scc1_l, s1_scc1_r, s1_scc2_l, s1_scc2_r;
  logic signed [SUM_W-1:0] s1_psg, s1_pcm, s1_tape;
  logic        [2:0]       s1_vol;

  // Stage 1 register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      valid1    <= 1'b0;
      s1_opll   <= '0;
      s1_opl3_l <= '0;
      s1_opl3_r <= '0;
      s1_scc1_l <= '0;
      s1_scc1_r <= '0;
      s1_scc2_l <= '0;
      s1_scc2_r <= '0;
      s1_psg    <= '0;
      s1_pcm    <= '0;
      s1_tape   <= '0;
      s1_vol    <= '0;
    end else begin
      valid1    <= valid0;
      s1_opll   <= SUM_W'(s0_opll);
      s1_opl3_l <= SUM_W'(s0_opl3_l);
      s1_opl3_r <= SUM_W'(s0_opl3_r);
      s1_scc1_l <= sc_scc1_l;
      s1_scc1_r <= sc_scc1_r;
      s1_scc2_l <= sc_scc2_l;
      s1_scc2_r <= sc_scc2_r;
      s1_psg    <= sc_psg;
      s1_pcm    <= sc_pcm;
      s1_tape   <= sc_tape;
      s1_vol    <= s0_vol;
    end
  end

  // Stage 2: full-precision sum (worst case stays well inside SUM_W)
  logic                    valid2;
  logic signed [SUM_W-1:0] sum [2];
  logic        [2:0]       s2_vol;

  // Stage 2 register; index 0 is left, 1 is right
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      valid2 <= 1'b0;
      sum[0] <= '0;
      sum[1] <= '0;
      s2_vol <= '0;
    end else begin
      valid2 <= valid1;
      sum[0] <= s1_opll + s1_opl3_l + s1_scc1_l + s1_scc2_l + s1_psg + s1_pcm + s1_tape;
      sum[1] <= s1_opll + s1_opl3_r + s1_scc1_r + s1_scc2_r + s1_psg + s1_pcm + s1_tape;
      s2_vol <= s1_vol;
    end
  end

  // Stage 3: DC block, volume, saturation
  logic signed [ACC_W-1:0] dc_acc [2];
  logic signed [Y_W-1:0]   dc_s   [2];
  logic signed [Y_W-1:0]   y_s    [2];
  logic signed [Y_W-1:0]   v_s    [2];
  logic signed [15:0]      sat_s  [2];

  // Per-channel DC removal, volume shift and symmetric clamp
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      // dc_acc holds dc scaled by 2^DC_SHIFT, so adding y realises dc += y>>>DC_SHIFT
      dc_s[c] = Y_W'(dc_acc[c] >>> DC_SHIFT);
      if (DC_BLOCK != 0) begin
        y_s[c] = Y_W'(sum[c]) - dc_s[c];
      end else begin
        y_s[c] = Y_W'(sum[c]);
      end
      if (s2_vol == 3'd0) begin
        v_s[c] = '0;
      end else begin
        v_s[c] = y_s[c] >>> (3'd7 - s2_vol);
      end
      if (v_s[c] > OUT_MAX) begin
        sat_s[c] = 16'sh7fff;
      end else if (v_s[c] < OUT_MIN) begin
        sat_s[c] = 16'sh8000;
      end else begin
        sat_s[c] = v_s[c][15:0];
      end
    end
  end

  // Output register and DC tracking state
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      audio_l_o    <= '0;
      audio_r_o    <= '0;
      sample_stb_o <= 1'b0;
      dc_acc[0]    <= '0;
      dc_acc[1]    <= '0;
    end else begin
      sample_stb_o <= valid2;
      if (valid2) begin
        audio_l_o <= sat_s[0];
        audio_r_o <= sat_s[1];
        if (DC_BLOCK != 0) begin
          dc_acc[0] <= dc_acc[0] + ACC_W'(y_s[0]);
          dc_acc[1] <= dc_acc[1] + ACC_W'(y_s[1]);
        end
      end
    end
  end

endmodule

// File: tb/tb_msx_audio_mixer.sv
// Directed testbench for msx_audio_mixer.
// dut: CE_DIV=448, DC block bypassed (timing, mixing, scaling, volume, clamp).
// dut_dc: short divider and DC_SHIFT=4 so the DC tracking settles quickly.
module tb_msx_audio_mixer;

  logic               clk_sys = 1'b0;
  logic               reset;
  logic signed [15:0] opll, opl3_l, opl3_r;
  logic signed [14:0] scc1_l, scc1_r, scc2_l, scc2_r;
  logic        [8:0]  psg;
  logic signed [7:0]  pcm;
  logic               tape, tape_en;
  logic        [2:0]  vol;
  logic signed [15:0] al, ar, dl, dr;
  logic               stb, dstb;

  int errors = 0;
  int checks = 0;

  always #5 clk_sys = ~clk_sys;

  msx_audio_mixer #(.CE_DIV(448), .SUM_W(20), .DC_BLOCK(0), .DC_SHIFT(10)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .opll_i(opll), .opl3_l_i(opl3_l), .opl3_r_i(opl3_r),
    .scc1_l_i(scc1_l), .scc1_r_i(scc1_r), .scc2_l_i(scc2_l), .scc2_r_i(scc2_r),
    .psg_i(psg), .pcm_i(pcm), .tape_i(tape), .tape_en(tape_en), .vol_i(vol),
    .audio_l_o(al), .audio_r_o(ar), .sample_stb_o(stb)
  );

  msx_audio_mixer #(.CE_DIV(8), .SUM_W(20), .DC_BLOCK(1), .DC_SHIFT(4)) dut_dc (
    .clk_sys(clk_sys), .reset(reset),
    .opll_i(opll), .opl3_l_i(opl3_l), .opl3_r_i(opl3_r),
    .scc1_l_i(scc1_l), .scc1_r_i(scc1_r), .scc2_l_i(scc2_l), .scc2_r_i(scc2_r),
    .psg_i(psg), .pcm_i(pcm), .tape_i(tape), .tape_en(tape_en), .vol_i(vol),
    .audio_l_o(dl), .audio_r_o(dr), .sample_stb_o(dstb)
  );

  task automatic set_idle();
    opll = 16'sd0; opl3_l = 16'sd0; opl3_r = 16'sd0;
    scc1_l = 15'sd0; scc1_r = 15'sd0; scc2_l = 15'sd0; scc2_r = 15'sd0;
    psg = 9'd256; pcm = 8'sd0; tape = 1'b0; tape_en = 1'b0; vol = 3'd7;
  endtask

  // Wait for the next main strobe; returns X on timeout so the caller's compare fails
  task automatic sample(output logic signed [15:0] l, output logic signed [15:0] r);
    int n = 0;
    bit got = 1'b0;
    l = 'x; r = 'x;
    while (!got && n < 1000) begin
      @(negedge clk_sys);
      n++;
      if (stb) begin got = 1'b1; l = al; r = ar; end
    end
  endtask

  task automatic dsample(output logic signed [15:0] l);
    int n = 0;
    bit got = 1'b0;
    l = 'x;
    while (!got && n < 100) begin
      @(negedge clk_sys);
      n++;
      if (dstb) begin got = 1'b1; l = dl; end
    end
  endtask

  task automatic test_reset();
    int pos [3];
    int cnt = 0;
    int wide = 0;
    bit prev = 1'b0;
    set_idle();
    reset = 1'b1;
    repeat (5) @(posedge clk_sys);
    @(negedge clk_sys);
    checks++; if (al !== 16'sd0) begin errors++; $display("FAIL reset_l: got %0d expected 0", al); end
    checks++; if (ar !== 16'sd0) begin errors++; $display("FAIL reset_r: got %0d expected 0", ar); end
    checks++; if (stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %0b expected 0", stb); end
    reset = 1'b0;
    for (int n = 1; n <= 1400; n++) begin
      @(negedge clk_sys);
      if (stb === 1'b1) begin
        if (cnt < 3) pos[cnt] = n;
        cnt++;
        if (prev) wide++;
      end
      prev = (stb === 1'b1);
    end
    checks++; if (cnt !== 3) begin errors++; $display("FAIL stb_count: got %0d expected 3", cnt); end
    checks++; if (wide !== 0) begin errors++; $display("FAIL stb_width: got %0d extra cycles expected 0", wide); end
    if (cnt >= 3) begin
      checks++; if (pos[0] !== 451) begin errors++; $display("FAIL stb_first: got cycle %0d expected 451", pos[0]); end
      checks++; if (pos[1] !== 899) begin errors++; $display("FAIL stb_second: got cycle %0d expected 899", pos[1]); end
      checks++; if (pos[2] !== 1347) begin errors++; $display("FAIL stb_third: got cycle %0d expected 1347", pos[2]); end
    end
  endtask

  task automatic test_basic_mix();
    logic signed [15:0] l, r;
    set_idle();
    opll = 16'sd1000;
    sample(l, r);
    checks++; if (l !== 16'sd1000) begin errors++; $display("FAIL mix_opll_l: got %0d expected 1000", l); end
    checks++; if (r !== 16'sd1000) begin errors++; $display("FAIL mix_opll_r: got %0d expected 1000", r); end
    scc1_l = 15'sd1000;
    sample(l, r);
    checks++; if (l !== 16'sd3000) begin errors++; $display("FAIL mix_scc_l: got %0d expected 3000", l); end
    checks++; if (r !== 16'sd1000) begin errors++; $display("FAIL mix_scc_r: got %0d expected 1000", r); end
  endtask

  task automatic test_scaling();
    logic signed [15:0] l, r;
    // pcm, tape_en, tape, psg -> expected value on both channels
    int v_pcm  [6] = '{-2, 0, 0, 0, 0, 0};
    bit v_ten  [6] = '{0, 1, 1, 0, 0, 0};
    bit v_tape [6] = '{0, 1, 0, 1, 0, 0};
    int v_psg  [6] = '{256, 256, 256, 256, 257, 0};
    int v_exp  [6] = '{-512, 4096, -4096, 0, 64, -16384};
    for (int i = 0; i < 6; i++) begin
      set_idle();
      pcm = 8'(v_pcm[i]); tape_en = v_ten[i]; tape = v_tape[i]; psg = 9'(v_psg[i]);
      sample(l, r);
      checks++; if (l !== 16'(v_exp[i])) begin errors++; $display("FAIL scale_l[%0d]: got %0d expected %0d", i, l, v_exp[i]); end
      checks++; if (r !== 16'(v_exp[i])) begin errors++; $display("FAIL scale_r[%0d]: got %0d expected %0d", i, r, v_exp[i]); end
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] l, r;
    set_idle();
    opll = 16'sd32767; opl3_l = 16'sd32767;
    sample(l, r);
    checks++; if (l !== 16'sd32767) begin errors++; $display("FAIL sat_pos_l: got %0d expected 32767", l); end
    checks++; if (r !== 16'sd32767) begin errors++; $display("FAIL sat_pos_r: got %0d expected 32767", r); end
    opll = -16'sd32768; opl3_l = 16'sd32767; opl3_r = -16'sd32768;
    sample(l, r);
    checks++; if (l !== -16'sd1) begin errors++; $display("FAIL sat_neg_l: got %0d expected -1", l); end
    checks++; if (r !== -16'sd32768) begin errors++; $display("FAIL sat_neg_r: got %0d expected -32768", r); end
  endtask

  task automatic test_volume();
    logic signed [15:0] l, r;
    set_idle();
    opll = 16'sd8000; vol = 3'd5;
    sample(l, r);
    checks++; if (l !== 16'sd2000) begin errors++; $display("FAIL vol5: got %0d expected 2000", l); end
    vol = 3'd0;
    sample(l, r);
    checks++; if (r !== 16'sd0) begin errors++; $display("FAIL vol0: got %0d expected 0", r); end
    opll = -16'sd1000; vol = 3'd3;
    sample(l, r);
    checks++; if (l !== -16'sd63) begin errors++; $display("FAIL vol3_neg: got %0d expected -63", l); end
    opll = 16'sd8000; vol = 3'd7;
    sample(l, r);
    checks++; if (l !== 16'sd8000) begin errors++; $display("FAIL vol7: got %0d expected 8000", l); end
    // Next capture has already happened; this change must wait one more sample
    repeat (446) @(negedge clk_sys);
    vol = 3'd5;
    sample(l, r);
    checks++; if (l !== 16'sd8000) begin errors++; $display("FAIL vol_late_old: got %0d expected 8000", l); end
    sample(l, r);
    checks++; if (l !== 16'sd2000) begin errors++; $display("FAIL vol_late_new: got %0d expected 2000", l); end
  endtask

  task automatic test_reset_midflight();
    logic signed [15:0] l, r;
    int first = -1;
    set_idle();
    opll = 16'sd1000;
    sample(l, r);
    checks++; if (l !== 16'sd1000) begin errors++; $display("FAIL mid_pre: got %0d expected 1000", l); end
    repeat (446) @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    checks++; if (al !== 16'sd0) begin errors++; $display("FAIL mid_rst_out: got %0d expected 0", al); end
    reset = 1'b0;
    for (int n = 1; n <= 460; n++) begin
      @(negedge clk_sys);
      if (stb === 1'b1 && first < 0) begin first = n; l = al; end
    end
    checks++; if (first !== 451) begin errors++; $display("FAIL mid_first_stb: got cycle %0d expected 451", first); end
    checks++; if (l !== 16'sd1000) begin errors++; $display("FAIL mid_post_val: got %0d expected 1000", l); end
  endtask

  task automatic test_dc_block();
    logic signed [15:0] y, prev;
    int small_at = -1;
    int bad_mono = 0;
    set_idle();
    reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    opll = 16'sd10000;
    reset = 1'b0;
    dsample(y);
    checks++; if (y !== 16'sd10000) begin errors++; $display("FAIL dc_first: got %0d expected 10000", y); end
    prev = y;
    for (int k = 1; k < 128; k++) begin
      dsample(y);
      if (!(y <= prev) || y < 0) bad_mono++;
      if (small_at < 0 && y < 16) small_at = k;
      prev = y;
    end
    checks++; if (bad_mono !== 0) begin errors++; $display("FAIL dc_decay_mono: got %0d bad steps expected 0", bad_mono); end
    checks++; if (!(small_at > 0)) begin errors++; $display("FAIL dc_settle: got sample %0d expected below 128", small_at); end
    opll = 16'sd0;
    dsample(y);
    checks++; if (!(y <= -16'sd9900 && y >= -16'sd10000)) begin errors++; $display("FAIL dc_undershoot: got %0d expected -10000..-9900", y); end
    prev = y; small_at = -1; bad_mono = 0;
    for (int k = 1; k < 128; k++) begin
      dsample(y);
      if (!(y >= prev) || y > 0) bad_mono++;
      if (small_at < 0 && y > -16) small_at = k;
      prev = y;
    end
    checks++; if (bad_mono !== 0) begin errors++; $display("FAIL dc_recover_mono: got %0d bad steps expected 0", bad_mono); end
    checks++; if (!(small_at > 0)) begin errors++; $display("FAIL dc_recover_settle: got sample %0d expected below 128", small_at); end
  endtask

  initial begin
    test_reset();
    test_basic_mix();
    test_scaling();
    test_saturation();
    test_volume();
    test_reset_midflight();
    test_dc_block();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
